// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Consumed by instr_fetch_unit and fetch_perf_counters.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;

    localparam logic [7:0]  RESET_VECTOR_DEF = 8'h00;
    localparam logic [15:0] NOP              = 16'h0000;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating 16-bit fetch and bubble event counters.
// Only instantiated when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        bubble_inc,
    output logic [15:0] perf_fetch_cnt,
    output logic [15:0] perf_bubble_cnt
);

    logic [15:0] fetch_cnt_q;
    logic [15:0] fetch_cnt_d;
    logic [15:0] bubble_cnt_q;
    logic [15:0] bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (fetch_inc) begin
            fetch_cnt_d = sat_inc16(fetch_cnt_q);
        end
        if (bubble_inc) begin
            bubble_cnt_d = sat_inc16(bubble_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives program memory, pairs data with address.
// Define FETCH_PERF_CNT_EN to add the perf_fetch_cnt/perf_bubble_cnt outputs.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W       = ADDR_W_DEF,
    parameter int                 INSTR_W      = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               rden,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [INSTR_W-1:0] mem_instr,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               halt_req,
    input  logic               wake,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic               if_valid,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetch_cnt,
    output logic [15:0]        perf_bubble_cnt
`endif
);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] f_pc_q;
    logic [ADDR_W-1:0] f_pc_d;
    logic              f_valid_q;
    logic              f_valid_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        f_pc_d    = f_pc_q;
        f_valid_d = f_valid_q;
        rden      = 1'b0;
        rd_addr   = '0;
        if (!rst) begin
            unique case (state_q)
                ST_BOOT: begin
                    rden      = 1'b1;
                    rd_addr   = pc_q;
                    pc_d      = pc_q + ADDR_W'(1);
                    f_pc_d    = pc_q;
                    f_valid_d = 1'b1;
                    state_d   = ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        rden      = 1'b1;
                        rd_addr   = redirect_addr;
                        pc_d      = redirect_addr + ADDR_W'(1);
                        f_pc_d    = redirect_addr;
                        f_valid_d = 1'b1;
                    end else if (halt_req) begin
                        f_valid_d = 1'b0;
                        state_d   = ST_HALT;
                    end else if (stall) begin
                        // Re-read the held word so mem_instr stays stable.
                        rden    = 1'b1;
                        rd_addr = f_pc_q;
                    end else begin
                        rden      = 1'b1;
                        rd_addr   = pc_q;
                        pc_d      = pc_q + ADDR_W'(1);
                        f_pc_d    = pc_q;
                        f_valid_d = 1'b1;
                    end
                end
                ST_HALT: begin
                    if (wake) begin
                        rden      = 1'b1;
                        rd_addr   = pc_q;
                        pc_d      = pc_q + ADDR_W'(1);
                        f_pc_d    = pc_q;
                        f_valid_d = 1'b1;
                        state_d   = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_VECTOR;
            f_pc_q    <= '0;
            f_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            f_pc_q    <= f_pc_d;
            f_valid_q <= f_valid_d;
        end
    end

    assign if_instr = mem_instr;
    assign if_pc    = f_pc_q;
    assign if_valid = f_valid_q & ~redirect_valid;
    assign halted   = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counters u_perf (
        .clk             (clk),
        .rst             (rst),
        .fetch_inc       (if_valid & ~stall),
        .bubble_inc      ((state_q == ST_RUN) & ~if_valid),
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a registered 256x16 memory model.
// Covers boot, stall, redirect, wrap, halt/wake and mid-stream reset.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        rden;
    logic [7:0]  rd_addr;
    logic [15:0] mem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_addr;
    logic        halt_req;
    logic        wake;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic        if_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_bubble_cnt;
`endif

    int n_cmp;
    int n_bad;

    logic [15:0] mem [256];

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .rden           (rden),
        .rd_addr        (rd_addr),
        .mem_instr      (mem_instr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt_req       (halt_req),
        .wake           (wake),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_instr <= rden ? mem[rd_addr] : 16'h0000;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #3;
    endtask

    task automatic chk_word(input string tag, input logic [7:0] a);
        check({tag, "_valid"}, 32'(if_valid), 32'd1);
        check({tag, "_pc"}, 32'(if_pc), 32'(a));
        check({tag, "_instr"}, 32'(if_instr), 32'(16'hA000 + 16'(a)));
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        mem_instr      = 16'h0000;
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 8'h00;
        halt_req       = 1'b0;
        wake           = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'hA000 + 16'(i);
        end

        cyc();
        cyc();
        smp();
        check("rst_rden", 32'(rden), 32'd0);
        check("rst_addr", 32'(rd_addr), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        cyc();
        rst = 1'b0;
        smp();
        check("boot_valid", 32'(if_valid), 32'd0);
        check("boot_rden", 32'(rden), 32'd1);
        check("boot_addr", 32'(rd_addr), 32'd0);

        for (int i = 0; i <= 5; i++) begin
            cyc();
            if (i == 5) stall = 1'b1;
            smp();
            chk_word("seq", 8'(i));
        end
        check("stall_addr0", 32'(rd_addr), 32'd5);
        for (int k = 0; k < 2; k++) begin
            cyc();
            smp();
            chk_word("stall", 8'h05);
            check("stall_addr", 32'(rd_addr), 32'd5);
        end
        cyc();
        stall = 1'b0;
        smp();
        chk_word("unstall", 8'h05);
        check("unstall_addr", 32'(rd_addr), 32'd6);

        for (int i = 6; i <= 9; i++) begin
            cyc();
            if (i == 9) begin
                redirect_valid = 1'b1;
                redirect_addr  = 8'h40;
            end
            smp();
            if (i < 9) chk_word("post_stall", 8'(i));
        end
        check("redir_valid", 32'(if_valid), 32'd0);
        check("redir_pc", 32'(if_pc), 32'h09);
        check("redir_addr", 32'(rd_addr), 32'h40);
        cyc();
        redirect_valid = 1'b0;
        smp();
        chk_word("tgt", 8'h40);
        cyc();
        redirect_valid = 1'b1;
        redirect_addr  = 8'hFE;
        smp();
        check("tgt1_pc", 32'(if_pc), 32'h41);

        for (int i = 0; i < 4; i++) begin
            cyc();
            redirect_valid = 1'b0;
            smp();
            chk_word("wrap", 8'(8'hFE + 8'(i)));
        end

        cyc();
        redirect_valid = 1'b1;
        redirect_addr  = 8'h10;
        smp();
        cyc();
        redirect_valid = 1'b0;
        halt_req       = 1'b1;
        smp();
        chk_word("halt_cyc", 8'h10);
        check("halt_cyc_rden", 32'(rden), 32'd0);
        check("halt_cyc_halted", 32'(halted), 32'd0);

        for (int h = 0; h < 4; h++) begin
            cyc();
            halt_req       = 1'b0;
            redirect_valid = (h == 1);
            redirect_addr  = 8'h80;
            wake           = (h == 3);
            smp();
            check("hlt_halted", 32'(halted), 32'd1);
            check("hlt_valid", 32'(if_valid), 32'd0);
            if (h < 3) begin
                check("hlt_rden", 32'(rden), 32'd0);
            end else begin
                check("wake_rden", 32'(rden), 32'd1);
                check("wake_addr", 32'(rd_addr), 32'h11);
            end
        end
        cyc();
        wake           = 1'b0;
        redirect_valid = 1'b0;
        smp();
        check("woke_halted", 32'(halted), 32'd0);
        chk_word("woke", 8'h11);
        cyc();
        smp();
        chk_word("woke1", 8'h12);

        cyc();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 8'h30;
        smp();
        check("sr_valid", 32'(if_valid), 32'd0);
        check("sr_addr", 32'(rd_addr), 32'h30);
        cyc();
        redirect_valid = 1'b0;
        smp();
        chk_word("sr_tgt", 8'h30);
        check("sr_tgt_addr", 32'(rd_addr), 32'h30);

        cyc();
        redirect_valid = 1'b1;
        redirect_addr  = 8'h55;
        rst            = 1'b1;
        smp();
        check("mrst_rden", 32'(rden), 32'd0);
        check("mrst_addr", 32'(rd_addr), 32'd0);
        cyc();
        smp();
        check("mrst1_valid", 32'(if_valid), 32'd0);
        check("mrst1_rden", 32'(rden), 32'd0);
        check("mrst1_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("mrst_pfetch", 32'(perf_fetch_cnt), 32'd0);
        check("mrst_pbubble", 32'(perf_bubble_cnt), 32'd0);
`endif
        cyc();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        rst            = 1'b0;
        smp();
        check("reboot_valid", 32'(if_valid), 32'd0);
        check("reboot_rden", 32'(rden), 32'd1);
        check("reboot_addr", 32'(rd_addr), 32'd0);
        cyc();
        smp();
        chk_word("reboot", 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the 256x16 program memory.
- Owns the program counter and drives the memory read port (rden, rd_addr).
- Pairs the memory's registered 16-bit read data with the address that produced it and presents {instr, pc, valid} to the decode stage.
- Handles stall, taken-branch/jump redirect and halt/wake.

Parameters:
ADDR_W, 8, program address width; PC wraps modulo 2^ADDR_W
INSTR_W, 16, instruction word width
RESET_VECTOR, 8'h00, first address fetched after reset

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high
rden  out  1  program memory read enable
rd_addr  out  ADDR_W  program memory read address
mem_instr  in  INSTR_W  program memory read data; valid one cycle after rden/rd_addr
stall  in  1  decode cannot accept; hold current output
redirect_valid  in  1  taken branch/jump from execute
redirect_addr  in  ADDR_W  redirect target
halt_req  in  1  enter HALT (SLEEP/BREAK executed)
wake  in  1  leave HALT
if_instr  out  INSTR_W  instruction to decode
if_pc  out  ADDR_W  address of if_instr
if_valid  out  1  if_instr/if_pc meaningful
halted  out  1  fetch is in HALT

Behaviour:
- Registers: pc (next address to fetch), f_pc (address of word arriving this cycle), f_valid, state ∈ {BOOT, RUN, HALT}.
- Outputs:
  - if_instr = mem_instr
  - if_pc = f_pc
  - if_valid = f_valid, forced 0 in any cycle with redirect_valid=1
  - halted = (state==HALT)
- Reset (rst=1 at posedge):
  - state=BOOT, pc=RESET_VECTOR, f_pc=0, f_valid=0.
  - While rst is high: rden=0, rd_addr=0.
- BOOT (one cycle): rden=1, rd_addr=pc; pc<=pc+1, f_pc<=pc, f_valid<=1, state<=RUN. First valid instruction appears 2 cycles after rst deasserts.
- RUN, per-cycle priority redirect > halt_req > stall > normal:
  - redirect: rden=1, rd_addr=redirect_addr; pc<=redirect_addr+1, f_pc<=redirect_addr, f_valid<=1. One-bubble penalty; target word valid next cycle.
  - halt_req: rden=0; f_valid<=0, pc unchanged (points to next unfetched word), state<=HALT. The word on if_* this cycle is still presented with its current validity.
  - stall: rden=1, rd_addr=f_pc (re-read held word so mem_instr stays stable); pc, f_pc, f_valid held.
  - normal: rden=1, rd_addr=pc; f_pc<=pc, f_valid<=1, pc<=pc+1.
- HALT:
  - rden=0, if_valid=0. Memory returns 0, which is a NOP.
  - wake → behaves as BOOT from held pc, state<=RUN.
  - redirect_valid in HALT is ignored.
- Wrap-around: pc 0xFF+1 → 0x00; redirect_addr 0xFF sets pc<=0x00.
- Simultaneous stall and redirect: redirect wins and the stalled word is discarded. Decode must not commit a word whose cycle carries redirect_valid.
- rst mid-operation overrides everything within the same cycle.
- Memory writes (we=2'b11) are outside this block. Self-modifying code is visible on the next fetch of that address. During a stall, a write to f_pc changes if_instr; this is accepted and documented behaviour.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[15:0], which counts cycles with if_valid=1 and stall=0.
  - Adds perf_bubble_cnt[15:0], which counts RUN cycles with if_valid=0.
  - Both counters saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and logic are absent. Fetch behaviour is identical either way.

Decomposition:
- Package fetch_pkg holds:
  - the state enum (BOOT, RUN, HALT)
  - ADDR_W/INSTR_W defaults and the RESET_VECTOR constant
  - the NOP encoding 16'h0000
- Sub-module fetch_perf_counters, instantiated only under FETCH_PERF_CNT_EN.
- The PC/next-address logic stays inline.

Test Plan:
- Reset release, memory preloaded mem[n]=16'hA000+n → if_valid rises 2 cycles after rst falls; if_pc=0,1,2… with if_instr=A000,A001,A002 on consecutive cycles.
- stall high for 3 cycles while if_pc=5 → if_pc=5, if_instr=A005, if_valid=1 held all 3 cycles, rd_addr=5; after release the next word is pc 6 with no gap or duplicate.
- redirect_valid with redirect_addr=0x40 while if_pc=9 → if_valid=0 that cycle; next cycle if_pc=0x40, if_instr=A040, then 0x41.
- Start at pc 0xFE with no stall → if_pc sequence FE, FF, 00, 01 (wrap).
- halt_req at if_pc=0x10 → halted=1, rden=0, if_valid=0 while halted; wake after 4 cycles → if_valid returns 2 cycles later with if_pc=0x11; redirect in HALT is ignored.
- rst asserted mid-stream during a stall+redirect → next cycle state BOOT, if_valid=0, rden=0 while rst is high; with FETCH_PERF_CNT_EN defined, both counters read 0.
